adc_scan_avg: RTL and testbench
===============================

// Module: adc_scan_avg
// PURPOSE
//  Downstream consumer and channel sequencer for adcinterface. Drives its chan input in a
//  round-robin scan, captures each 12-bit result, and averages 2**LOG2_AVG samples per channel.
//  Holds the latest average per channel in an 8-entry table readable by the display/control logic.
// PARAMETERS
//  FIRST_CHAN  0  first channel of scan (0..7)
//  LAST_CHAN   7  last channel of scan (FIRST_CHAN..7)
//  LOG2_AVG    2  log2 of samples averaged per channel (0..4)
//  DISCARD     1  samples dropped after each channel change (0..3), mux settling
// PORTS
//  clk         in   1   system clock; sole clock
//  reset_n     in   1   synchronous reset, active low
//  enable      in   1   1 = scan runs; 0 = idle
//  ADC_CONVST  in   1   tap of adcinterface ADC_CONVST, synchronous to clk
//  result      in   12  adcinterface result
//  chan        out  3   channel to adcinterface
//  avg_valid   out  1   one-cycle strobe: new average on avg_data/avg_chan
//  avg_chan    out  3   channel of avg_data
//  avg_data    out  12  averaged result
//  sweep_done  out  1   one-cycle strobe, coincident with avg_valid for LAST_CHAN
//  rd_chan     in   3   table read address
//  rd_data     out  12  table[rd_chan], registered, 1-cycle latency
// BEHAVIOUR
//  - Reset (reset_n=0 at posedge): chan=FIRST_CHAN, state IDLE, acc/counters=0, avg_valid=0,
//    sweep_done=0, avg_chan=0, avg_data=0, rd_data=0, all 8 table entries=0.
//  - Sample event: conv_d <= ADC_CONVST; edge = ADC_CONVST & ~conv_d. No synchronizer.
//    At an edge, result holds the previous frame, converted with the chan value held during it.
//  - chan changes only in the cycle after an edge; it is constant for a whole frame.
//  - FSM:
//    IDLE: chan=FIRST_CHAN. enable=1 -> DISCARD (dcnt=0), or ACCUM if DISCARD=0.
//    DISCARD: each edge dcnt++; on the edge where dcnt reaches DISCARD -> ACCUM
//      (scnt=0, acc=0). The first edge after leaving IDLE is always discarded, even if DISCARD=0.
//    ACCUM: each edge acc += result; scnt++.
//      On the 2**LOG2_AVG-th edge, in the next cycle:
//        - avg = (acc+result) >> LOG2_AVG (floor, no rounding);
//        - table[chan] <= avg; avg_valid=1; avg_chan=chan; avg_data=avg;
//        - chan advances (LAST_CHAN wraps to FIRST_CHAN);
//        - state -> DISCARD (or stays ACCUM with acc cleared if DISCARD=0).
//  - acc width 12+LOG2_AVG; it never overflows. Max input 4095 x16 gives avg 4095.
//  - FIRST_CHAN==LAST_CHAN: chan never changes; DISCARD still applies between averages.
//  - enable=0 in any state: next cycle IDLE, chan=FIRST_CHAN, acc/counters cleared.
//    A partial average is dropped and no avg_valid is issued. The table is retained.
//  - reset_n=0 mid-scan: full reset as above, including the table.
//  - Edges while IDLE are ignored.
//  - rd_data <= table[rd_chan] every cycle.
//    A read of the entry written in the same cycle returns the old value; the new value appears next cycle.
//  - avg_valid and sweep_done are never asserted in consecutive cycles.
//    avg_chan/avg_data hold their values between strobes.
// TESTING
//  1. Reset: hold reset_n=0 for 2 clk -> chan=0, avg_valid=0, rd_data=0 for all rd_chan 0..7.
//  2. Defaults, result held at 12'h123 per frame -> edges 1 and 2 discarded, avg_valid
//     after edge 6 with avg_chan=0, avg_data=12'h123; chan=1 the cycle after.
//  3. Averaging: samples 100,101,102,104 on chan 3 -> avg_data=101 (floor of 101.75);
//     all 4095 -> 4095, no overflow.
//  4. Full sweep with result=chan*12'h111 -> avg_valid for chans 0..7 in order, sweep_done
//     only with chan 7, chan wraps 7->0, table[k]=k*12'h111.
//  5. enable=0 after 2 of 4 samples on chan 5 -> no avg_valid, chan=0 next cycle, table[5] unchanged.
//     Re-enable -> scan restarts at chan 0 with discard.
//  6. Read/write collision: rd_chan=2 held while table[2] written -> rd_data shows old value one cycle,
//     new value next cycle. Repeat with LOG2_AVG=0, DISCARD=0: one average per edge after the first.

Source files
------------

// File: rtl/adc_scan_avg.sv
// ---------------------------------------------------------------------------
// adc_scan_avg
//   Channel sequencer and averager placed downstream of adcinterface.
//   Steps the ADC channel select round-robin from FIRST_CHAN to LAST_CHAN,
//   drops the settling samples after every channel change, averages
//   2**LOG2_AVG samples per channel and keeps the latest average per
//   channel in an 8-entry table.
//
// Ports
//   clk         system clock (sole clock)
//   reset_n     synchronous reset, active low
//   enable      1 = scan runs, 0 = idle (partial average dropped)
//   ADC_CONVST  tap of adcinterface ADC_CONVST, synchronous to clk
//   result      12-bit conversion result from adcinterface
//   chan        channel select driven to adcinterface
//   avg_valid   one-cycle strobe: new average on avg_chan/avg_data
//   avg_chan    channel of avg_data (held between strobes)
//   avg_data    averaged result (held between strobes)
//   sweep_done  one-cycle strobe with the avg_valid of LAST_CHAN
//   rd_chan     table read address
//   rd_data     table[rd_chan], registered, one cycle latency
//
// Output handshake: avg_valid is a pure strobe with no ready/backpressure.
// The consumer must take avg_chan/avg_data in the single cycle avg_valid is
// high; the values stay stable afterwards until the next strobe.
// ---------------------------------------------------------------------------
module adc_scan_avg #(
    parameter int unsigned FIRST_CHAN = 0,
    parameter int unsigned LAST_CHAN  = 7,
    parameter int unsigned LOG2_AVG   = 2,
    parameter int unsigned DISCARD    = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        ADC_CONVST,
    input  logic [11:0] result,
    output logic [2:0]  chan,
    output logic        avg_valid,
    output logic [2:0]  avg_chan,
    output logic [11:0] avg_data,
    output logic        sweep_done,
    input  logic [2:0]  rd_chan,
    output logic [11:0] rd_data
);

    localparam int          ACC_W     = 12 + LOG2_AVG;
    localparam int          NSAMP     = 1 << LOG2_AVG;
    localparam logic [4:0]  SCNT_LAST = 5'(NSAMP - 1);
    localparam logic [2:0]  DISC_N    = 3'(DISCARD);
    localparam logic [2:0]  CH_FIRST  = 3'(FIRST_CHAN);
    localparam logic [2:0]  CH_LAST   = 3'(LAST_CHAN);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DISCARD = 2'd1,
        S_ACCUM   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               first_q, first_d;
    logic               conv_q, conv_d;
    logic [2:0]         dcnt_q, dcnt_d;
    logic [4:0]         scnt_q, scnt_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [2:0]         chan_q, chan_d;
    logic               avg_valid_q, avg_valid_d;
    logic               sweep_done_q, sweep_done_d;
    logic [2:0]         avg_chan_q, avg_chan_d;
    logic [11:0]        avg_data_q, avg_data_d;
    logic [11:0]        rd_data_q, rd_data_d;
    logic [11:0]        tbl_q [8];
    logic [11:0]        tbl_d [8];

    logic               conv_edge;
    logic [ACC_W-1:0]   sum;
    logic [11:0]        avg;

    // Rising edge of ADC_CONVST marks the end of a frame; result then holds
    // the conversion of the frame that just ended.
    assign conv_edge = ADC_CONVST & ~conv_q;

    // acc holds at most NSAMP-1 samples, so adding the last one cannot
    // overflow ACC_W bits.
    assign sum = acc_q + ACC_W'(result);
    assign avg = 12'(sum >> LOG2_AVG);

    always_comb begin
        state_d      = state_q;
        first_d      = first_q;
        conv_d       = ADC_CONVST;
        dcnt_d       = dcnt_q;
        scnt_d       = scnt_q;
        acc_d        = acc_q;
        chan_d       = chan_q;
        avg_valid_d  = 1'b0;
        sweep_done_d = 1'b0;
        avg_chan_d   = avg_chan_q;
        avg_data_d   = avg_data_q;
        tbl_d        = tbl_q;
        // Reads the pre-write table, so a same-cycle write shows up one
        // cycle later.
        rd_data_d    = tbl_q[rd_chan];

        if (!enable) begin
            state_d = S_IDLE;
            chan_d  = CH_FIRST;
            first_d = 1'b0;
            dcnt_d  = '0;
            scnt_d  = '0;
            acc_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // The frame in flight when the scan starts has unknown
                    // history, so its edge is always dropped (first_q).
                    state_d = (DISCARD == 0) ? S_ACCUM : S_DISCARD;
                    first_d = 1'b1;
                    chan_d  = CH_FIRST;
                    dcnt_d  = '0;
                    scnt_d  = '0;
                    acc_d   = '0;
                end
                S_DISCARD: begin
                    if (conv_edge) begin
                        if (first_q) begin
                            first_d = 1'b0;
                        end else if (dcnt_q + 3'd1 == DISC_N) begin
                            state_d = S_ACCUM;
                            dcnt_d  = '0;
                            scnt_d  = '0;
                            acc_d   = '0;
                        end else begin
                            dcnt_d = dcnt_q + 3'd1;
                        end
                    end
                end
                S_ACCUM: begin
                    if (conv_edge) begin
                        if (first_q) begin
                            first_d = 1'b0;
                        end else if (scnt_q == SCNT_LAST) begin
                            tbl_d[chan_q] = avg;
                            avg_valid_d   = 1'b1;
                            sweep_done_d  = (chan_q == CH_LAST);
                            avg_chan_d    = chan_q;
                            avg_data_d    = avg;
                            chan_d        = (chan_q == CH_LAST) ? CH_FIRST : chan_q + 3'd1;
                            acc_d         = '0;
                            scnt_d        = '0;
                            dcnt_d        = '0;
                            state_d       = (DISCARD == 0) ? S_ACCUM : S_DISCARD;
                        end else begin
                            acc_d  = sum;
                            scnt_d = scnt_q + 5'd1;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            first_q      <= 1'b0;
            conv_q       <= 1'b0;
            dcnt_q       <= '0;
            scnt_q       <= '0;
            acc_q        <= '0;
            chan_q       <= CH_FIRST;
            avg_valid_q  <= 1'b0;
            sweep_done_q <= 1'b0;
            avg_chan_q   <= '0;
            avg_data_q   <= '0;
            rd_data_q    <= '0;
            tbl_q        <= '{default: '0};
        end else begin
            state_q      <= state_d;
            first_q      <= first_d;
            conv_q       <= conv_d;
            dcnt_q       <= dcnt_d;
            scnt_q       <= scnt_d;
            acc_q        <= acc_d;
            chan_q       <= chan_d;
            avg_valid_q  <= avg_valid_d;
            sweep_done_q <= sweep_done_d;
            avg_chan_q   <= avg_chan_d;
            avg_data_q   <= avg_data_d;
            rd_data_q    <= rd_data_d;
            tbl_q        <= tbl_d;
        end
    end

    assign chan       = chan_q;
    assign avg_valid  = avg_valid_q;
    assign sweep_done = sweep_done_q;
    assign avg_chan   = avg_chan_q;
    assign avg_data   = avg_data_q;
    assign rd_data    = rd_data_q;

endmodule

// File: tb/tb_adc_scan_avg.sv
// ---------------------------------------------------------------------------
// tb_adc_scan_avg
//   Directed bench for adc_scan_avg. dut1 uses the default parameters,
//   dut2 uses LOG2_AVG=0 / DISCARD=0. Both share clock, reset, ADC_CONVST,
//   result and rd_chan; each has its own enable.
// ---------------------------------------------------------------------------
module tb_adc_scan_avg;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        en1, en2;
    logic        convst;
    logic [11:0] result;
    logic [2:0]  rd_chan;

    logic [2:0]  chan1, avg_chan1, chan2, avg_chan2;
    logic        avg_valid1, sweep1, avg_valid2, sweep2;
    logic [11:0] avg_data1, rd_data1, avg_data2, rd_data2;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [2:0]  ch;
        logic [11:0] s0, s1, s2, s3;
        logic [11:0] exp_avg;
        logic        exp_sweep;
        logic [2:0]  exp_next;
    } vec_t;

    vec_t vecs [15];

    adc_scan_avg dut1 (
        .clk(clk), .reset_n(reset_n), .enable(en1), .ADC_CONVST(convst),
        .result(result), .chan(chan1), .avg_valid(avg_valid1),
        .avg_chan(avg_chan1), .avg_data(avg_data1), .sweep_done(sweep1),
        .rd_chan(rd_chan), .rd_data(rd_data1)
    );

    adc_scan_avg #(.FIRST_CHAN(0), .LAST_CHAN(7), .LOG2_AVG(0), .DISCARD(0)) dut2 (
        .clk(clk), .reset_n(reset_n), .enable(en2), .ADC_CONVST(convst),
        .result(result), .chan(chan2), .avg_valid(avg_valid2),
        .avg_chan(avg_chan2), .avg_data(avg_data2), .sweep_done(sweep2),
        .rd_chan(rd_chan), .rd_data(rd_data2)
    );

    // clock / reset block
    always #5 clk = ~clk;

    // all driving and sampling happens 1 time unit after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // one ADC frame boundary: low gap, then a single-cycle high pulse;
    // returns right after the edge has been clocked in
    task automatic pulse(input logic [11:0] r);
        convst = 1'b0;
        result = r;
        step();
        step();
        convst = 1'b1;
        step();
        convst = 1'b0;
    endtask

    // one discard edge followed by four accumulated samples on dut1
    task automatic run_chan(input vec_t v);
        pulse(12'hABC);
        chk("discard_no_valid", avg_valid1, 0);
        pulse(v.s0);
        chk("chan_held", chan1, v.ch);
        chk("s0_no_valid", avg_valid1, 0);
        pulse(v.s1);
        chk("s1_no_valid", avg_valid1, 0);
        pulse(v.s2);
        chk("s2_no_valid", avg_valid1, 0);
        pulse(v.s3);
        chk("avg_valid", avg_valid1, 1);
        chk("avg_chan", avg_chan1, v.ch);
        chk("avg_data", avg_data1, v.exp_avg);
        chk("sweep_done", sweep1, v.exp_sweep);
        chk("chan_next", chan1, v.exp_next);
    endtask

    initial begin
        vec_t v;

        // pass 1 continues after the chan 0 run of the defaults test
        vecs[0] = '{3'd1, 12'h111, 12'h111, 12'h111, 12'h111, 12'h111, 1'b0, 3'd2};
        vecs[1] = '{3'd2, 12'd0,   12'd1,   12'd2,   12'd3,   12'd1,   1'b0, 3'd3};
        vecs[2] = '{3'd3, 12'd100, 12'd101, 12'd102, 12'd104, 12'd101, 1'b0, 3'd4};
        vecs[3] = '{3'd4, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 1'b0, 3'd5};
        vecs[4] = '{3'd5, 12'h555, 12'h556, 12'h557, 12'h558, 12'h556, 1'b0, 3'd6};
        vecs[5] = '{3'd6, 12'h666, 12'h666, 12'h666, 12'h666, 12'h666, 1'b0, 3'd7};
        vecs[6] = '{3'd7, 12'h777, 12'h777, 12'h777, 12'h777, 12'h777, 1'b1, 3'd0};
        // pass 2: full sweep with k*0x111 on every channel
        vecs[7]  = '{3'd0, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 1'b0, 3'd1};
        vecs[8]  = '{3'd1, 12'h111, 12'h111, 12'h111, 12'h111, 12'h111, 1'b0, 3'd2};
        vecs[9]  = '{3'd2, 12'h222, 12'h222, 12'h222, 12'h222, 12'h222, 1'b0, 3'd3};
        vecs[10] = '{3'd3, 12'h333, 12'h333, 12'h333, 12'h333, 12'h333, 1'b0, 3'd4};
        vecs[11] = '{3'd4, 12'h444, 12'h444, 12'h444, 12'h444, 12'h444, 1'b0, 3'd5};
        vecs[12] = '{3'd5, 12'h555, 12'h555, 12'h555, 12'h555, 12'h555, 1'b0, 3'd6};
        vecs[13] = '{3'd6, 12'h666, 12'h666, 12'h666, 12'h666, 12'h666, 1'b0, 3'd7};
        vecs[14] = '{3'd7, 12'h777, 12'h777, 12'h777, 12'h777, 12'h777, 1'b1, 3'd0};

        reset_n = 1'b0;
        en1     = 1'b0;
        en2     = 1'b0;
        convst  = 1'b0;
        result  = 12'h000;
        rd_chan = 3'd0;

        // 1. reset
        step();
        step();
        chk("rst_chan", chan1, 0);
        chk("rst_avg_valid", avg_valid1, 0);
        chk("rst_avg_data", avg_data1, 0);
        reset_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            rd_chan = 3'(k);
            step();
            chk("rst_table", rd_data1, 0);
        end

        // 2. defaults, constant 0x123: edges 1-2 dropped, valid after edge 6
        en1 = 1'b1;
        step();
        for (int i = 1; i <= 5; i++) begin
            pulse(12'h123);
            chk("dflt_no_valid", avg_valid1, 0);
            chk("dflt_chan0", chan1, 0);
        end
        pulse(12'h123);
        chk("dflt_valid", avg_valid1, 1);
        chk("dflt_avg_chan", avg_chan1, 0);
        chk("dflt_avg_data", avg_data1, 12'h123);
        chk("dflt_sweep", sweep1, 0);
        chk("dflt_chan1", chan1, 1);
        step();
        chk("dflt_strobe_drop", avg_valid1, 0);
        chk("dflt_data_hold", avg_data1, 12'h123);

        // 3 + 4. averaging corners then a full sweep with wrap
        for (int i = 0; i < 15; i++) begin
            run_chan(vecs[i]);
        end
        for (int k = 0; k < 8; k++) begin
            rd_chan = 3'(k);
            step();
            chk("sweep_table", rd_data1, 32'(k * 12'h111));
        end

        // 6a. collision: rd_chan=2 while table[2] is rewritten
        rd_chan = 3'd2;
        for (int k = 0; k < 3; k++) begin
            v = '{3'(k), 12'h0A0 + 12'(k), 12'h0A0 + 12'(k), 12'h0A0 + 12'(k),
                  12'h0A0 + 12'(k), 12'h0A0 + 12'(k), 1'b0, 3'(k + 1)};
            run_chan(v);
        end
        chk("coll_old", rd_data1, 12'h222);
        step();
        chk("coll_new", rd_data1, 12'h0A2);
        chk("no_back_to_back", avg_valid1, 0);
        for (int k = 3; k < 5; k++) begin
            v = '{3'(k), 12'h0A0 + 12'(k), 12'h0A0 + 12'(k), 12'h0A0 + 12'(k),
                  12'h0A0 + 12'(k), 12'h0A0 + 12'(k), 1'b0, 3'(k + 1)};
            run_chan(v);
        end

        // 5. drop enable after 2 of 4 samples on chan 5
        pulse(12'hABC);
        pulse(12'h7F0);
        pulse(12'h7F0);
        chk("part_chan5", chan1, 5);
        en1 = 1'b0;
        step();
        chk("dis_no_valid", avg_valid1, 0);
        chk("dis_chan0", chan1, 0);
        for (int i = 0; i < 2; i++) begin
            pulse(12'h7FF);
            chk("idle_edge_no_valid", avg_valid1, 0);
            chk("idle_edge_chan0", chan1, 0);
        end
        rd_chan = 3'd5;
        step();
        chk("dis_table5_kept", rd_data1, 12'h555);
        en1 = 1'b1;
        step();
        for (int i = 1; i <= 5; i++) begin
            pulse(12'h0F0);
            chk("reen_no_valid", avg_valid1, 0);
            chk("reen_chan0", chan1, 0);
        end
        pulse(12'h0F0);
        chk("reen_valid", avg_valid1, 1);
        chk("reen_avg_chan", avg_chan1, 0);
        chk("reen_avg_data", avg_data1, 12'h0F0);

        // 6b. LOG2_AVG=0, DISCARD=0: one average per edge after the first
        en1 = 1'b0;
        en2 = 1'b1;
        rd_chan = 3'd2;
        step();
        pulse(12'h300);
        chk("d2_first_dropped", avg_valid2, 0);
        chk("d2_chan0", chan2, 0);
        for (int i = 0; i < 4; i++) begin
            pulse(12'h301 + 12'(i));
            chk("d2_valid", avg_valid2, 1);
            chk("d2_avg_chan", avg_chan2, i);
            chk("d2_avg_data", avg_data2, 12'h301 + 12'(i));
            chk("d2_chan_next", chan2, i + 1);
            if (i == 2) begin
                chk("d2_coll_old", rd_data2, 12'h000);
                step();
                chk("d2_coll_new", rd_data2, 12'h303);
                chk("d2_strobe_drop", avg_valid2, 0);
            end
        end

        // reset mid-scan clears the table as well
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        rd_chan = 3'd3;
        step();
        chk("midrst_table", rd_data1, 0);
        chk("midrst_chan", chan2, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
